// File: rtl/tstate_sequencer_pkg.sv
// Shared definitions for the T-state sequencer.
//   t_state_e   : 3-bit state encoding exported on t_state
//   CL_*        : cycle_len input codes (T-states per M-cycle)
//   NUM_SRC_DEF : default number of data-bus sources
//   cycle_len_to_len : maps a cycle_len code to its T-state count
package tstate_sequencer_pkg;

    typedef enum logic [2:0] {
        T1    = 3'd0,
        T2    = 3'd1,
        TW    = 3'd2,
        T3    = 3'd3,
        T4    = 3'd4,
        T5    = 3'd5,
        THALT = 3'd6,
        THOLD = 3'd7
    } t_state_e;

    localparam logic [1:0] CL_3  = 2'd0;
    localparam logic [1:0] CL_4  = 2'd1;
    localparam logic [1:0] CL_5A = 2'd2;
    localparam logic [1:0] CL_5B = 2'd3;

    localparam int NUM_SRC_DEF = 10;

    // T-state counts held in len_q
    localparam logic [2:0] LEN_3 = 3'd3;
    localparam logic [2:0] LEN_4 = 3'd4;
    localparam logic [2:0] LEN_5 = 3'd5;

    function automatic logic [2:0] cycle_len_to_len(input logic [1:0] code);
        case (code)
            CL_3:    return LEN_3;
            CL_4:    return LEN_4;
            default: return LEN_5;   // both CL_5A and CL_5B
        endcase
    endfunction

endpackage

// File: rtl/tstate_sequencer_src_decoder.sv
// One-hot data-bus source decoder (purely combinational).
//   src_code   in  SRC_W    source index; codes >= NUM_SRC select nothing
//   src_onehot out NUM_SRC  one-hot select, all-zero for out-of-range codes
module src_decoder #(
    parameter int NUM_SRC = 10,
    parameter int SRC_W   = 4
) (
    input  logic [SRC_W-1:0]   src_code,
    output logic [NUM_SRC-1:0] src_onehot
);

    always_comb begin
        src_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_code == SRC_W'(i))
                src_onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/tstate_sequencer.sv
// Machine-cycle T-state sequencer with wait-state, halt and (optional) bus
// hold handling, plus registered one-hot data-bus source selects.
//
// Optional feature macro: TSTATE_HOLD_EN -- builds THOLD, halted_q and hlda.
// Without it, hold is ignored and hlda is tied low.
//
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   ready                low in T2/TW inserts wait states
//   hold                 bus hold request (TSTATE_HOLD_EN only)
//   halt_req             enter THALT at the end of the current M-cycle
//   int_req              leaves THALT
//   cycle_len            T-states in the M-cycle, sampled in T1
//   src_code             data-bus source index
//   t_state              current state
//   sync/wait_out/hlda   T1 / TW / THOLD indicators
//   m_done               final T-state of the M-cycle
//   src_sel, bus_float   one-hot source selects and their NOR
module tstate_sequencer
    import tstate_sequencer_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int SRC_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic               hold,
    input  logic               halt_req,
    input  logic               int_req,
    input  logic [1:0]         cycle_len,
    input  logic [SRC_W-1:0]   src_code,
    output t_state_e           t_state,
    output logic               sync,
    output logic               wait_out,
    output logic               hlda,
    output logic               m_done,
    output logic [NUM_SRC-1:0] src_sel,
    output logic               bus_float
);

    t_state_e             state_q, state_d;
    logic [2:0]           len_q;
    logic                 end_cycle;
    logic [NUM_SRC-1:0]   dec_onehot;

`ifdef TSTATE_HOLD_EN
    // Remembers whether THOLD was entered from THALT so hold release
    // resumes the halt rather than starting a new M-cycle.
    logic halted_q;
`else
    logic unused_hold;
    assign unused_hold = hold;
`endif

    src_decoder #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_src_decoder (
        .src_code   (src_code),
        .src_onehot (dec_onehot)
    );

    always_comb begin
        state_d   = state_q;
        end_cycle = 1'b0;
        case (state_q)
            T1: state_d = T2;
            T2, TW: state_d = ready ? T3 : TW;
            T3: begin
                if (len_q == LEN_3) end_cycle = 1'b1;
                else                state_d   = T4;
            end
            T4: begin
                if (len_q == LEN_4) end_cycle = 1'b1;
                else                state_d   = T5;
            end
            T5: end_cycle = 1'b1;
            THALT: begin
`ifdef TSTATE_HOLD_EN
                if (hold)         state_d = THOLD;
                else if (int_req) state_d = T1;
`else
                if (int_req)      state_d = T1;
`endif
            end
`ifdef TSTATE_HOLD_EN
            THOLD: begin
                if (!hold) state_d = halted_q ? THALT : T1;
            end
`endif
            default: state_d = T1;
        endcase

        // Hold outranks halt; a halt_req seen together with hold is dropped.
        if (end_cycle) begin
`ifdef TSTATE_HOLD_EN
            if (hold)          state_d = THOLD;
            else if (halt_req) state_d = THALT;
            else               state_d = T1;
`else
            if (halt_req)      state_d = THALT;
            else               state_d = T1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T1;
            len_q   <= LEN_3;
            src_sel <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T1)
                len_q <= cycle_len_to_len(cycle_len);
            // Sources drive the bus only during the data T-states.
            if (state_d == T3 || state_d == T4 || state_d == T5)
                src_sel <= dec_onehot;
            else
                src_sel <= '0;
        end
    end

`ifdef TSTATE_HOLD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            halted_q <= 1'b0;
        else if (state_d == THOLD && state_q != THOLD)
            halted_q <= (state_q == THALT);
    end

    assign hlda = (state_q == THOLD);
`else
    assign hlda = 1'b0;
`endif

    assign t_state   = state_q;
    assign sync      = (state_q == T1);
    assign wait_out  = (state_q == TW);
    assign m_done    = ((state_q == T3) && (len_q == LEN_3)) ||
                       ((state_q == T4) && (len_q == LEN_4)) ||
                       (state_q == T5);
    assign bus_float = ~|src_sel;

endmodule

// File: doc/tstate_sequencer.md
TSTATE_SEQUENCER -- requirements
Module: tstate_sequencer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 10, the number of internal data-bus sources, each with one one-hot select.
REQ-002 SHALL have parameter SRC_W, default 4, the width of the source code.
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-high, reset.
REQ-004 Ports SHALL be:
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
  ready  in  1  memory/IO ready; low in T2 or TW inserts a wait state
  hold  in  1  bus hold request
  halt_req  in  1  enter halt at end of current M-cycle
  int_req  in  1  wakes the sequencer from halt
  cycle_len  in  2  T-states in this M-cycle: 0=3, 1=4, 2=5, 3=5; sampled in T1
  src_code  in  SRC_W  bus source index; 0..NUM_SRC-1 valid, others mean no source
  t_state  out  3  current state encoding (package enum)
  sync  out  1  high in T1
  wait_out  out  1  high in TW
  hlda  out  1  high in THOLD
  m_done  out  1  high during the final T-state of an M-cycle
  src_sel  out  NUM_SRC  one-hot data-bus source selects, all-zero or exactly one bit set
  bus_float  out  1  high when src_sel is all-zero

Function
REQ-005 States SHALL be T1, T2, TW, T3, T4, T5, THALT and THOLD, with one state register updated on each rising clk.
REQ-006 T1 SHALL go to T2 unconditionally and SHALL latch cycle_len into len_q.
REQ-007 T2 SHALL go to T3 if ready=1, otherwise to TW; TW SHALL stay in TW until ready=1, then go to T3.
REQ-008 T3 SHALL end the cycle if len_q=3; T4 SHALL end it if len_q=4; T5 SHALL always end it.
REQ-009 At cycle end the next state SHALL be chosen by priority: hold=1 -> THOLD; halt_req=1 -> THALT; otherwise T1.
REQ-010 THALT SHALL go to THOLD if hold=1, else to T1 if int_req=1, else stay in THALT.
REQ-011 THOLD SHALL stay while hold=1; on hold=0 it SHALL return to THALT if it was entered from THALT, otherwise to T1, using a halted_q flag.
REQ-012 m_done SHALL be a combinational decode of state and len_q, high only in the final T-state.
REQ-013 src_sel SHALL be registered with the state:
  - it SHALL hold the one-hot decode of src_code when the next state is T3, T4 or T5 and src_code<NUM_SRC;
  - it SHALL be all-zero otherwise.
REQ-014 bus_float SHALL equal NOR(src_sel); src_sel SHALL never have more than one bit set.
REQ-015 When hold and halt_req are both high at cycle end, THOLD SHALL win; halt_req SHALL not be remembered.

Reset
REQ-016 reset=1 SHALL immediately force the following, regardless of the current state, including mid-cycle, TW or THOLD:
  - state=T1, len_q=3, halted_q=0, src_sel=0;
  - outputs therefore sync=1, wait_out=0, hlda=0, m_done=0, bus_float=1.
REQ-017 The first rising clk after reset deasserts SHALL move the state from T1 to T2.

Configuration
REQ-018 With TSTATE_HOLD_EN defined, the hold/THOLD/hlda behaviour SHALL be as specified.
REQ-019 Without TSTATE_HOLD_EN:
  - THOLD and halted_q SHALL not be built;
  - hold SHALL be ignored and hlda SHALL be tied 0.

Structure
REQ-020 A shared package SHALL hold the state enum with its 3-bit encoding, the cycle_len codes and the NUM_SRC default.
REQ-021 The one-hot source decoder SHALL be a sub-module named src_decoder, combinational, with src_code in and NUM_SRC one-hot out.

Verification
REQ-022 The bench SHALL cover these scenarios:
  - Reset release, cycle_len=0, ready=1: states T1,T2,T3,T1; m_done high only in T3.
  - cycle_len=2, ready low for 2 cycles in T2: states T1,T2,TW,TW,T3,T4,T5; wait_out high exactly 2 cycles.
  - src_code=7 driven during T2 -> src_sel=10'b0010000000 in T3; src_code=12 -> src_sel=0 and bus_float=1.
  - halt_req=1 at T3 end -> THALT held 5 cycles; int_req=1 -> T1 next clock.
  - With TSTATE_HOLD_EN: hold=1 during THALT -> THOLD with hlda=1; hold=0 -> returns to THALT, not T1.
  - reset asserted in TW -> T1 asynchronously with src_sel=0; no further TW after release with ready=1.
